ascii_scroll_mux: RTL and testbench
===================================

ASCII_SCROLL_MUX -- requirements
Module: ascii_scroll_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles each digit stays selected (1 kHz per digit at 100 MHz).
REQ-002 Parameter SCROLL_DIV, default 25000000, clk cycles per scroll step (4 steps/s at 100 MHz).
REQ-003 Parameter MSG_DEPTH, default 16, message buffer depth in characters.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  message-byte write strobe, one byte per cycle asserted.
REQ-007 wr_addr  input  4  buffer index for wr_data.
REQ-008 wr_data  input  8  ASCII byte to store.
REQ-009 len_wr  input  1  strobe loading len.
REQ-010 len  input  5  message length, 0..16.
REQ-011 scroll_en  input  1  level; 1 enables scrolling.
REQ-012 ascii_char  output  8  registered ASCII code for the selected digit, fed to the Seven_Segment_Display decoder.
REQ-013 an  output  4  registered active-low anode enables; an[3] leftmost, an[0] rightmost.

Function
REQ-014 Message buffer SHALL be MSG_DEPTH x 8; wr_en SHALL write msg[wr_addr]=wr_data on the next edge.
REQ-015 len_wr SHALL load msg_len=min(len,16), clear pos to 0 and clear the scroll counter on the same edge.
REQ-016 Refresh counter SHALL count 0..REFRESH_DIV-1; at terminal count digit index SHALL advance 0->1->2->3->0.
REQ-017 an SHALL be ~(4'b0001 << digit); exactly one bit low outside reset.
REQ-018 Digit d SHALL display window slot k=3-d; slot k maps to index i=(pos+k) mod msg_len.
REQ-019 When scrolling is inactive (scroll_en=0 or msg_len<=4), slot k>=msg_len SHALL output 8'h00 (blank).
REQ-020 msg_len=0 SHALL force ascii_char=8'h00 on every digit; scroll_en ignored.
REQ-021 Scroll counter SHALL run only while scroll_en=1 and msg_len>4; at terminal count pos SHALL become (pos==msg_len-1)?0:pos+1.
REQ-022 scroll_en deasserted SHALL freeze pos and the scroll counter; reassertion resumes from the frozen values.
REQ-023 ascii_char and an SHALL be registered and update on the same edge, one cycle after digit or pos change; no cross-digit ghosting cycle is permitted.
REQ-024 A write to a currently displayed index SHALL appear on ascii_char no later than one refresh period plus 2 cycles later.
REQ-025 Simultaneous wr_en and len_wr SHALL both take effect on the same edge.
REQ-026 wr_addr >= msg_len SHALL still be written and become visible after a later len increase.

Reset
REQ-027 rst_n low SHALL immediately force an=4'b1111, ascii_char=8'h00, digit=0, pos=0, msg_len=0, both counters 0, all msg bytes 8'h00.
REQ-028 After rst_n release the first clock edge SHALL load an=4'b1110; reset asserted mid-scroll SHALL discard all state.

Structure
REQ-029 Shared package SHALL hold DIGITS=4, ASCII_BLANK=8'h00, MAX_LEN=16 and the default divider constants.
REQ-030 One parameterised sub-module tick_gen (divide-by-N, one-cycle tick pulse) SHALL be instantiated twice, for refresh and scroll.

Verification (REFRESH_DIV=4, SCROLL_DIV=16)
REQ-031 Reset release, no writes -> an cycles 1110,1101,1011,0111, each held 4 cycles; ascii_char=8'h00 throughout.
REQ-032 Load "HELP", len=4, scroll_en=0 -> an=0111 with 8'h48, 1011 with 8'h45, 1101 with 8'h4C, 1110 with 8'h50.
REQ-033 Load "HI", len=2 -> an[3] shows 8'h48, an[2] shows 8'h49, an[1] and an[0] show 8'h00; scroll_en=1 leaves pos at 0.
REQ-034 Load "HELLO1", len=6, scroll_en=1 -> after 16 cycles window reads "ELLO"; at pos=4 it reads "O1HE"; after 6 steps pos=0.
REQ-035 Mid-scroll rst_n pulse -> an=1111 and ascii_char=8'h00 asynchronously; after release len=20 loads msg_len=16, pos=0.
REQ-036 Write msg[0]=8'h5A while "HELP" is shown -> an=0111 digit shows 8'h5A within 6 cycles; len=0 -> all digits 8'h00.

Source files
------------

// File: rtl/ascii_scroll_mux_pkg.sv
// ascii_scroll_mux_pkg -- shared constants and helpers for the scrolling ASCII display mux.
// Rev 1.0
`default_nettype none

package ascii_scroll_mux_pkg;

  localparam int DIGITS           = 4;
  localparam logic [7:0] ASCII_BLANK = 8'h00;
  localparam int MAX_LEN          = 16;
  localparam int DEF_REFRESH_DIV  = 100000;
  localparam int DEF_SCROLL_DIV   = 25000000;

  localparam int ADDR_W  = 4;
  localparam int LEN_W   = 5;
  localparam int DIGIT_W = 2;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : l;
  endfunction

  // pos+slot never reaches 2*len while pos < len and slot < DIGITS <= len, so one subtract suffices
  function automatic logic [ADDR_W-1:0] wrap_index(input logic [LEN_W-1:0] s,
                                                   input logic [LEN_W-1:0] l);
    logic [LEN_W-1:0] r;
    r = (s >= l) ? (s - l) : s;
    return ADDR_W'(r);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ascii_scroll_mux_if.sv
// ascii_scroll_mux_if -- message write port, control and display outputs of the scroll mux.
// Rev 1.0
`default_nettype none

interface ascii_scroll_mux_if;
  import ascii_scroll_mux_pkg::*;

  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [7:0]           wr_data;
  logic                 len_wr;
  logic [LEN_W-1:0]     len;
  logic                 scroll_en;
  logic [7:0]           ascii_char;
  logic [DIGITS-1:0]    an;

  modport master (
    output wr_en, wr_addr, wr_data, len_wr, len, scroll_en,
    input  ascii_char, an
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len_wr, len, scroll_en,
    output ascii_char, an
  );

endinterface

`default_nettype wire

// File: rtl/ascii_scroll_mux_tick_gen.sv
// tick_gen -- divide-by-N counter producing a one-cycle tick on its terminal count.
// Rev 1.0
`default_nettype none

module tick_gen #(
  parameter int N = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic en,
  input  wire logic clr,
  output logic      tick
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt;

  assign tick = en && !clr && (cnt == W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ascii_scroll_mux.sv
// ascii_scroll_mux -- drives a 4-digit display from a scrollable ASCII message buffer.
// Rev 1.0
`default_nettype none

module ascii_scroll_mux
  import ascii_scroll_mux_pkg::*;
#(
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int SCROLL_DIV  = DEF_SCROLL_DIV,
  parameter int MSG_DEPTH   = MAX_LEN
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  ascii_scroll_mux_if.slave  bus
);

  logic [7:0]         msg [MSG_DEPTH];
  logic [LEN_W-1:0]   msg_len;
  logic [ADDR_W-1:0]  pos;
  logic [DIGIT_W-1:0] digit;

  logic refresh_tick;
  logic scroll_tick;
  logic scroll_run;

  logic [DIGIT_W-1:0] slot;
  logic [LEN_W-1:0]   slot_sum;
  logic [ADDR_W-1:0]  rd_idx;
  logic               blank;
  logic [7:0]         next_char;
  logic [DIGITS-1:0]  next_an;

  assign scroll_run = bus.scroll_en && (msg_len > LEN_W'(DIGITS));

  tick_gen #(.N(REFRESH_DIV)) u_refresh (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .clr   (1'b0),
    .tick  (refresh_tick)
  );

  tick_gen #(.N(SCROLL_DIV)) u_scroll (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (scroll_run),
    .clr   (bus.len_wr),
    .tick  (scroll_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
        msg[i] <= ASCII_BLANK;
      end
    end else if (bus.wr_en) begin
      msg[bus.wr_addr] <= bus.wr_data;
    end
  end

  // A length load restarts the window; it wins over a coincident scroll tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_len <= '0;
      pos     <= '0;
    end else if (bus.len_wr) begin
      msg_len <= clamp_len(bus.len);
      pos     <= '0;
    end else if (scroll_tick) begin
      if (LEN_W'(pos) == msg_len - LEN_W'(1)) begin
        pos <= '0;
      end else begin
        pos <= pos + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (refresh_tick) begin
      digit <= digit + DIGIT_W'(1);
    end
  end

  always_comb begin
    slot      = DIGIT_W'(DIGITS - 1) - digit;
    slot_sum  = LEN_W'(pos) + LEN_W'(slot);
    rd_idx    = wrap_index(slot_sum, msg_len);
    blank     = (msg_len == '0) || (!scroll_run && (LEN_W'(slot) >= msg_len));
    next_char = blank ? ASCII_BLANK : msg[rd_idx];
    next_an   = ~(DIGITS'(1) << digit);
  end

  // Anode and character share one register stage so they always switch together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an         <= '1;
      bus.ascii_char <= ASCII_BLANK;
    end else begin
      bus.an         <= next_an;
      bus.ascii_char <= next_char;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ascii_scroll_mux.sv
// tb_ascii_scroll_mux -- directed self-checking bench for ascii_scroll_mux (REFRESH_DIV=4, SCROLL_DIV=16).
// Rev 1.0
`default_nettype none

module tb_ascii_scroll_mux;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  ascii_scroll_mux_if bus();

  ascii_scroll_mux #(
    .REFRESH_DIV (4),
    .SCROLL_DIV  (16),
    .MSG_DEPTH   (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    step(1);
    bus.wr_en   = 1'b0;
  endtask

  task automatic load_len(input logic [4:0] l);
    bus.len_wr = 1'b1;
    bus.len    = l;
    step(1);
    bus.len_wr = 1'b0;
  endtask

  // Samples one full refresh rotation and packs {digit3,digit2,digit1,digit0}
  task automatic capture(input string tag, input logic [31:0] exp);
    logic [31:0] win;
    logic [3:0]  seen;
    int          bad;
    win  = '1;
    seen = '0;
    bad  = 0;
    step(2);
    for (int c = 0; c < 16; c++) begin
      step(1);
      case (bus.an)
        4'b0111: begin win[31:24] = bus.ascii_char; seen[3] = 1'b1; end
        4'b1011: begin win[23:16] = bus.ascii_char; seen[2] = 1'b1; end
        4'b1101: begin win[15:8]  = bus.ascii_char; seen[1] = 1'b1; end
        4'b1110: begin win[7:0]   = bus.ascii_char; seen[0] = 1'b1; end
        default: bad++;
      endcase
    end
    check({tag, "_window"}, win, exp);
    check({tag, "_an_onehot"}, {28'd0, seen} | 32'(bad << 4), 32'h0000000F);
  endtask

  initial begin
    logic [3:0] exp_an;
    logic [3:0] prev_an;
    logic       found;

    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.len_wr    = 1'b0;
    bus.len       = '0;
    bus.scroll_en = 1'b0;

    step(3);
    check("reset_an", {28'd0, bus.an}, 32'h0000000F);
    check("reset_char", {24'd0, bus.ascii_char}, 32'h0);
    rst_n = 1'b1;

    // Refresh rotation with an empty buffer
    for (int d = 0; d < 4; d++) begin
      exp_an = ~(4'b0001 << d);
      step(1);
      check("rot_an_first", {28'd0, bus.an}, {28'd0, exp_an});
      check("rot_char", {24'd0, bus.ascii_char}, 32'h0);
      step(3);
      check("rot_an_hold", {28'd0, bus.an}, {28'd0, exp_an});
    end

    // Static four-character message
    wr(4'd0, 8'h48); wr(4'd1, 8'h45); wr(4'd2, 8'h4C); wr(4'd3, 8'h50);
    load_len(5'd4);
    capture("help", 32'h48454C50);

    // Write into the leftmost digit while it is being shown
    prev_an = bus.an;
    found   = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step(1);
      found   = (bus.an == 4'b0111) && (prev_an != 4'b0111);
      prev_an = bus.an;
    end
    check("wr_sync_found", {31'd0, found}, 32'd1);
    wr(4'd0, 8'h5A);
    found = 1'b0;
    for (int c = 0; c < 5 && !found; c++) begin
      step(1);
      found = (bus.an == 4'b0111) && (bus.ascii_char == 8'h5A);
    end
    check("wr_visible", {31'd0, found}, 32'd1);
    capture("help_z", 32'h5A454C50);

    load_len(5'd0);
    capture("len0", 32'h00000000);
    bus.scroll_en = 1'b1;
    capture("len0_scroll", 32'h00000000);
    bus.scroll_en = 1'b0;

    // Short message: blanks on the right, scrolling has no effect
    wr(4'd0, 8'h48); wr(4'd1, 8'h49);
    load_len(5'd2);
    capture("hi", 32'h48490000);
    wr(4'd2, 8'h21);
    capture("hi_hidden", 32'h48490000);
    bus.scroll_en = 1'b1;
    step(40);
    capture("hi_scroll", 32'h48490000);
    load_len(5'd3);
    capture("hi_len3", 32'h48492100);
    bus.scroll_en = 1'b0;

    // Scrolling six-character message, frozen for each inspection
    wr(4'd0, 8'h48); wr(4'd1, 8'h45); wr(4'd2, 8'h4C);
    wr(4'd3, 8'h4C); wr(4'd4, 8'h4F); wr(4'd5, 8'h31);
    bus.scroll_en = 1'b1;
    load_len(5'd6);
    step(16);
    bus.scroll_en = 1'b0;
    capture("pos1", 32'h454C4C4F);
    bus.scroll_en = 1'b1;
    step(48);
    bus.scroll_en = 1'b0;
    capture("pos4", 32'h4F314845);
    bus.scroll_en = 1'b1;
    step(32);
    bus.scroll_en = 1'b0;
    capture("pos0_wrap", 32'h48454C4C);

    // Asynchronous reset in the middle of scrolling
    bus.scroll_en = 1'b1;
    step(5);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_an", {28'd0, bus.an}, 32'h0000000F);
    check("async_rst_char", {24'd0, bus.ascii_char}, 32'h0);
    step(2);
    rst_n         = 1'b1;
    bus.scroll_en = 1'b0;
    load_len(5'd6);
    capture("rst_cleared", 32'h00000000);

    // Oversized length clamps to 16; write and length load on the same edge
    wr(4'd0, 8'h41); wr(4'd1, 8'h42); wr(4'd2, 8'h43); wr(4'd15, 8'h5A);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd3;
    bus.wr_data = 8'h44;
    bus.len_wr  = 1'b1;
    bus.len     = 5'd20;
    step(1);
    bus.wr_en   = 1'b0;
    bus.len_wr  = 1'b0;
    capture("len20", 32'h41424344);
    bus.scroll_en = 1'b1;
    step(240);
    bus.scroll_en = 1'b0;
    capture("len16_pos15", 32'h5A414243);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
